// File: rtl/cup_alu_control.sv
// cup_alu_control: registered datapath ALU (logic, add/sub, shifts), 1-cycle latency.
// Ports: clk, rst_n (async low), ALUctl[3:0], A, B -> ALUOut, Zero. Option macro: ALU_SLT_EN.
module cup_alu_control #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       ALUctl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_res;
  logic [WIDTH-1:0]   r_out;
  logic               r_zero;

  assign w_shamt = B[SHAMT_W-1:0];

  always_comb begin
    w_res = '0;
    unique case (ALUctl)
      4'b0000: w_res = A & B;
      4'b0001: w_res = A | B;
      4'b0010: w_res = A + B;
      4'b0011: w_res = A - B;
      4'b0100: w_res = A ^ B;
      4'b0101: w_res = A << w_shamt;
      4'b0111: w_res = A >> w_shamt;
      4'b0110: w_res = $signed(A) >>> w_shamt;
`ifdef ALU_SLT_EN
      4'b1000: w_res = {{(WIDTH-1){1'b0}},
                        ($signed(A) < $signed(B))};
      4'b1001: w_res = {{(WIDTH-1){1'b0}},
                        (A < B)};
`endif
      default: w_res = '0;
    endcase
  end

  // Zero follows the value being registered, not the old ALUOut.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_zero <= 1'b1;
    end else begin
      r_out  <= w_res;
      r_zero <= (w_res == '0);
    end
  end

  assign ALUOut = r_out;
  assign Zero   = r_zero;

endmodule

// File: tb/tb_cup_alu_control.sv
// tb_cup_alu_control: random + directed checks of cup_alu_control
// against a behavioural ALU model evaluated at each rising edge.
module tb_cup_alu_control;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [3:0]   ALUctl = '0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] ALUOut;
  logic         Zero;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;
  logic [W-1:0] m_out;

  cup_alu_control #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .ALUctl(ALUctl),
    .A(A), .B(B), .ALUOut(ALUOut), .Zero(Zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_alu(
    input logic [3:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    int unsigned s;
    logic [W-1:0] r;
    s = int'(b % W);
    r = '0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a + b;
      4'd3: r = a - b;
      4'd4: r = a ^ b;
      4'd5: r = a << s;
      4'd7: r = a >> s;
      4'd6: r = a[W-1] ? ~((~a) >> s) : (a >> s);
`ifdef ALU_SLT_EN
      4'd8: r = (a[W-1] != b[W-1]) ? W'(a[W-1]) : W'(a < b);
      4'd9: r = W'(a < b);
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_out = '0;
    else        m_out = ref_alu(ALUctl, A, B);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (ALUOut !== m_out || Zero !== (m_out == '0)) begin
        n_bad++;
        $display("FAIL model t=%0t: got %h/%b want %h/%b",
                 $time, ALUOut, Zero, m_out, (m_out == '0));
      end
    end
  end

  task automatic chk(input string nm, input logic [W-1:0] ev,
                     input logic ez);
    n_cmp++;
    if (ALUOut !== ev || Zero !== ez) begin
      n_bad++;
      $display("FAIL %s: got %h/%b want %h/%b",
               nm, ALUOut, Zero, ev, ez);
    end
  endtask

  task automatic run(input string nm, input logic [3:0] op,
                     input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] ev, input logic ez);
    @(negedge clk); #1;
    ALUctl = op; A = a; B = b;
    @(posedge clk); #1;
    chk(nm, ev, ez);
  endtask

  logic [3:0] base [8] = '{4'd0, 4'd1, 4'd2, 4'd3,
                           4'd4, 4'd5, 4'd7, 4'd6};

  initial begin
    logic [W-1:0] a, b;
    #1 rst_n = 1'b0;
    #1 chk_en = 1'b1;
    ALUctl = 4'd2; A = 64'h1234; B = 64'h99;
    repeat (3) @(posedge clk);
    #1 chk("reset", 64'h0, 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    ALUctl = 4'd2; A = 64'd5; B = 64'd3;
    #1 chk("hold_after_release", 64'h0, 1'b1);
    @(posedge clk); #1;
    chk("add_5_3", 64'h8, 1'b0);

    run("and_ones", 4'd0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run("or", 4'd1, 64'hF0F0_F0F0_F0F0_F0F0,
        64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run("xor", 4'd4, 64'hFFFF_0000_FFFF_0000,
        64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_0F0F_F0F0_0F0F, 1'b0);
    run("sub_5_3", 4'd3, 64'd5, 64'd3, 64'h2, 1'b0);
    run("sub_5_5", 4'd3, 64'd5, 64'd5, 64'h0, 1'b1);
    run("add_wrap", 4'd2, '1, 64'd1, 64'h0, 1'b1);
    run("sll_1_3", 4'd5, 64'h1, 64'd3, 64'h8, 1'b0);
    run("srl_80_3", 4'd7, 64'h80, 64'd3, 64'h10, 1'b0);
    run("sra_neg", 4'd6, 64'hFFFF_FFFF_FFFF_FFF0, 64'd2,
        64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    run("sll_b41", 4'd5, 64'h1, 64'h41, 64'h2, 1'b0);
    run("sra_by0", 4'd6, 64'h8000_0000_0000_0001, 64'h40,
        64'h8000_0000_0000_0001, 1'b0);
    run("srl_63", 4'd7, 64'h8000_0000_0000_0000, 64'd63,
        64'h1, 1'b0);
    run("illegal_f", 4'hF, 64'hFF, 64'hFF, 64'h0, 1'b1);
`ifdef ALU_SLT_EN
    run("slt", 4'd8, '1, 64'd1, 64'h1, 1'b0);
    run("sltu", 4'd9, '1, 64'd1, 64'h0, 1'b1);
`else
    run("code8_off", 4'd8, '1, 64'd1, 64'h0, 1'b1);
    run("code9_off", 4'd9, 64'd1, '1, 64'h0, 1'b1);
`endif

    for (int i = 0; i < 16; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      run("b2b", base[i % 8], a, b,
          ref_alu(base[i % 8], a, b),
          ref_alu(base[i % 8], a, b) == '0);
    end

    @(negedge clk); #1;
    ALUctl = 4'd1; A = 64'hAA; B = 64'h55;
    #2 rst_n = 1'b0;
    #1 chk("midreset", 64'h0, 1'b1);
    @(negedge clk); #1;
    rst_n = 1'b1;
    ALUctl = 4'd2; A = 64'd7; B = 64'd9;
    @(posedge clk); #1;
    chk("after_midreset", 64'd16, 1'b0);

    for (int i = 0; i < 400; i++) begin
      @(negedge clk); #1;
      ALUctl = 4'($urandom_range(0, 15));
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: B = 64'($urandom_range(0, 130));
        1: A = B;
        2: A = 64'(-$signed(64'($urandom_range(0, 5))));
        default: ;
      endcase
    end
    @(negedge clk); #1;
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
